// File: rtl/safe_pkg.sv
// Shared types and defaults for the safe controller: FSM states, default
// combination, lockout defaults and the sel encoding.
package safe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PROG0,
        PROG1,
        PROG2,
        COMMIT,
        LOCKED
    } state_t;

    localparam logic [7:0] DEF_C0_VAL   = 8'h12;
    localparam logic [7:0] DEF_C1_VAL   = 8'h34;
    localparam logic [7:0] DEF_C2_VAL   = 8'h56;
    localparam int         MAX_FAIL_DEF = 3;
    localparam int         LOCK_MS_DEF  = 30000;
    localparam logic [1:0] SEL_NONE     = 2'd3;

    function automatic logic isBcdByte(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// 16-bit loadable down-counter used to time the attempt lockout.
module lockout_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic [15:0] value,
    output logic        zero
);

    logic [15:0] value_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= 16'd0;
        end else if (load) begin
            value_q <= load_val;
        end else if (dec) begin
            value_q <= value_q - 16'd1;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == 16'd0);

endmodule

// File: rtl/code_store_ctrl.sv
// Combination store, dial programming FSM and failed-attempt lockout for the
// safe; runs on the 1 ms divided clock.
module code_store_ctrl
    import safe_pkg::*;
#(
    parameter logic [7:0] DEF_C0   = DEF_C0_VAL,
    parameter logic [7:0] DEF_C1   = DEF_C1_VAL,
    parameter logic [7:0] DEF_C2   = DEF_C2_VAL,
    parameter int         MAX_FAIL = MAX_FAIL_DEF,
    parameter int         LOCK_MS  = LOCK_MS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic       dirch,
    input  logic       prog_req,
    input  logic       door_cls,
    input  logic       safe_open,
    input  logic       attempt_fail,
    output logic [7:0] exp_code,
    output logic       prog_active,
    output logic [1:0] prog_step,
    output logic       prog_done,
    output logic       lockout,
    output logic [1:0] fail_cnt
);

    localparam logic [15:0] LOCK_LOAD  = 16'(LOCK_MS - 1);
    localparam logic [1:0]  MAX_FAIL_L = 2'(MAX_FAIL);

    state_t          state_q;
    logic [2:0][7:0] code_q;
    logic [2:0][7:0] shadow_q;
    logic [1:0]      failCnt_q;
    logic [1:0]      progStep_q;
    logic            progActive_q;
    logic            progDone_q;
    logic            lockout_q;
    logic            progPrev_q;
    logic            openPrev_q;

    logic [7:0]  dialByte;
    logic        progRise;
    logic        openRise;
    logic        abortProg;
    logic        failLock;
    logic        timerLoad;
    logic        timerDec;
    logic [15:0] timerValue;
    logic        timerZero;

    assign dialByte  = {bcd1, bcd0};
    assign progRise  = prog_req & ~progPrev_q;
    assign openRise  = safe_open & ~openPrev_q;
    assign abortProg = door_cls | ~safe_open | progRise;
    assign failLock  = attempt_fail && !openRise && (failCnt_q != MAX_FAIL_L)
                       && ((failCnt_q + 2'd1) == MAX_FAIL_L);
    assign timerLoad = (state_q == IDLE) && failLock;
    assign timerDec  = (state_q == LOCKED) && (timerValue != 16'd0);

    lockout_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timerLoad),
        .load_val (LOCK_LOAD),
        .dec      (timerDec),
        .value    (timerValue),
        .zero     (timerZero)
    );

    always_comb begin
        exp_code = 8'h00;
        case (sel)
            2'd0:     exp_code = code_q[0];
            2'd1:     exp_code = code_q[1];
            2'd2:     exp_code = code_q[2];
            SEL_NONE: exp_code = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            code_q       <= {DEF_C2, DEF_C1, DEF_C0};
            shadow_q     <= '0;
            failCnt_q    <= 2'd0;
            progStep_q   <= 2'd0;
            progActive_q <= 1'b0;
            progDone_q   <= 1'b0;
            lockout_q    <= 1'b0;
            progPrev_q   <= 1'b0;
            openPrev_q   <= 1'b0;
        end else begin
            progPrev_q <= prog_req;
            openPrev_q <= safe_open;
            progDone_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (failLock) begin
                        state_q   <= LOCKED;
                        lockout_q <= 1'b1;
                    end else if (progRise && safe_open && !door_cls) begin
                        state_q      <= PROG0;
                        progActive_q <= 1'b1;
                        progStep_q   <= 2'd0;
                    end
                end
                PROG0, PROG1, PROG2: begin
                    if (abortProg) begin
                        state_q      <= IDLE;
                        progActive_q <= 1'b0;
                        progStep_q   <= 2'd0;
                    end else if (dirch && isBcdByte(dialByte)) begin
                        shadow_q[progStep_q] <= dialByte;
                        if (state_q == PROG2) begin
                            // Commit lands on this edge so the new code is
                            // readable in the same cycle prog_done is high.
                            code_q       <= {dialByte, shadow_q[1], shadow_q[0]};
                            progDone_q   <= 1'b1;
                            progActive_q <= 1'b0;
                            progStep_q   <= 2'd0;
                            state_q      <= COMMIT;
                        end else begin
                            progStep_q <= progStep_q + 2'd1;
                            state_q    <= (state_q == PROG0) ? PROG1 : PROG2;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                LOCKED: begin
                    if (timerZero) begin
                        state_q   <= IDLE;
                        lockout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (openRise) begin
                failCnt_q <= 2'd0;
            end else if (state_q == IDLE && attempt_fail && failCnt_q != MAX_FAIL_L) begin
                failCnt_q <= failCnt_q + 2'd1;
            end else if (state_q == LOCKED && timerZero) begin
                failCnt_q <= 2'd0;
            end
        end
    end

    assign prog_active = progActive_q;
    assign prog_step   = progStep_q;
    assign prog_done   = progDone_q;
    assign lockout     = lockout_q;
    assign fail_cnt    = failCnt_q;

endmodule
